// File: rtl/backoff_ctrl.sv
// Channel-access backoff controller: waits a DIFS idle period, counts down random
// backoff slots while the channel stays idle, then holds grant until done.
module backoff_ctrl #(
   parameter int unsigned W          = 4,
   parameter int unsigned DIFS_TICKS = 40,
   parameter int unsigned SLOT_TICKS = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         tick,
   input  logic         start,
   input  logic [W-1:0] slots,
   input  logic         busy,
   input  logic         done,
   output logic         grant,
   output logic [1:0]   state,
   output logic [W-1:0] remaining
);

   localparam int unsigned MAX_TICKS = (DIFS_TICKS > SLOT_TICKS) ? DIFS_TICKS : SLOT_TICKS;
   localparam int unsigned CW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] DIFS    = 2'd1;
   localparam logic [1:0] BACKOFF = 2'd2;
   localparam logic [1:0] GRANT   = 2'd3;

   localparam logic [CW-1:0] DIFS_LAST = CW'(DIFS_TICKS - 1);
   localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_TICKS - 1);

   logic [1:0]    state_nxt;
   logic [W-1:0]  rem_nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and counter update; busy always wins over tick
   always_comb begin
      state_nxt = state;
      rem_nxt   = remaining;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = DIFS;
               rem_nxt   = slots;
               cnt_nxt   = '0;
            end
         end
         DIFS: begin
            if (busy) begin
               cnt_nxt = '0;
            end else if (tick) begin
               if (cnt == DIFS_LAST) begin
                  cnt_nxt   = '0;
                  state_nxt = (remaining == '0) ? GRANT : BACKOFF;
               end else begin
                  cnt_nxt = cnt + CW'(1);
               end
            end
         end
         BACKOFF: begin
            if (busy) begin
               state_nxt = DIFS;
               cnt_nxt   = '0;
            end else if (tick) begin
               if (cnt == SLOT_LAST) begin
                  cnt_nxt = '0;
                  // Saturate at zero; the last slot hands over to GRANT
                  if (remaining != '0) begin
                     rem_nxt = remaining - W'(1);
                  end
                  if (remaining <= W'(1)) begin
                     state_nxt = GRANT;
                  end
               end else begin
                  cnt_nxt = cnt + CW'(1);
               end
            end
         end
         GRANT: begin
            if (done) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Datapath registers; grant tracks the next state so it matches state exactly
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt       <= '0;
         remaining <= '0;
         grant     <= 1'b0;
      end else begin
         cnt       <= cnt_nxt;
         remaining <= rem_nxt;
         grant     <= (state_nxt == GRANT);
      end
   end

endmodule

// File: tb/tb_backoff_ctrl.sv
// Bench for backoff_ctrl: directed latency scenarios plus randomized traffic,
// all checked every cycle against a tick-accounting reference model.
module tb_backoff_ctrl;

   localparam int unsigned W    = 4;
   localparam int          DIFS = 4;
   localparam int          SLOT = 2;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         tick = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] slots = '0;
   logic         busy = 1'b0;
   logic         done = 1'b0;
   logic         grant;
   logic [1:0]   state;
   logic [W-1:0] remaining;

   int checks = 0;
   int errors = 0;
   bit run_cmp = 1'b0;

   backoff_ctrl #(.W(W), .DIFS_TICKS(DIFS), .SLOT_TICKS(SLOT)) dut (
      .clk(clk), .rst(rst), .tick(tick), .start(start), .slots(slots),
      .busy(busy), .done(done), .grant(grant), .state(state), .remaining(remaining)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: phase plus number of consecutive idle ticks earned in that phase
   int m_phase;   // 0 idle, 1 difs, 2 backoff, 3 grant
   int m_left;    // slots still owed
   int m_quiet;   // quiet ticks gathered toward the current DIFS or slot
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_phase = 0; m_left = 0; m_quiet = 0;
      end else if (m_phase == 0) begin
         if (start) begin m_phase = 1; m_left = int'(slots); m_quiet = 0; end
      end else if (m_phase == 3) begin
         if (done) m_phase = 0;
      end else if (busy) begin
         m_phase = 1; m_quiet = 0;
      end else if (tick) begin
         m_quiet = m_quiet + 1;
         if (m_phase == 1 && m_quiet == DIFS) begin
            m_quiet = 0;
            m_phase = (m_left == 0) ? 3 : 2;
         end else if (m_phase == 2 && m_quiet == SLOT) begin
            m_quiet = 0;
            m_left  = m_left - 1;
            if (m_left == 0) m_phase = 3;
         end
      end
   end

   always @(negedge clk) begin
      if (run_cmp) begin
         chk("state", int'(state), m_phase);
         chk("grant", int'(grant), (m_phase == 3) ? 1 : 0);
         chk("remaining", int'(remaining), m_left);
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   // Issue a request and count clocks from the sampling edge until grant is seen
   task automatic latency(input int sl, input int div, input bit restart, input int exp, input string nm);
      int k;
      bit got;
      start = 1'b1; slots = W'(sl); tick = 1'b0; busy = 1'b0;
      step();
      start = 1'b0;
      k = 0; got = 1'b0;
      while (k < 200 && !got) begin
         k++;
         tick = (k % div == 0);
         start = restart && (k == 2);
         slots = restart ? W'(7) : W'(sl);
         step();
         if (grant) got = 1'b1;
      end
      start = 1'b0;
      chk(nm, k, exp);
      done = 1'b1;
      step();
      done = 1'b0;
      chk({nm, "_release_state"}, int'(state), 0);
      chk({nm, "_release_grant"}, int'(grant), 0);
   endtask

   initial begin
      int k;
      #3;
      chk("reset_state", int'(state), 0);
      chk("reset_grant", int'(grant), 0);
      chk("reset_remaining", int'(remaining), 0);
      #10 rst = 1'b1;
      step();
      run_cmp = 1'b1;

      latency(3, 1, 1'b0, 10, "lat_slots3");
      latency(0, 1, 1'b0, 4, "lat_slots0");
      latency(1, 3, 1'b0, 18, "lat_tick_div3");
      latency(2, 1, 1'b1, 8, "lat_restart_ignored");

      // Busy for two cycles while BACKOFF with remaining=2
      start = 1'b1; slots = W'(3); tick = 1'b1;
      step();
      start = 1'b0;
      k = 0;
      while (k < 50 && !(state == 2'd2 && remaining == W'(2))) begin k++; step(); end
      chk("busy_reach_backoff2", (k < 50) ? 1 : 0, 1);
      busy = 1'b1; step(); step(); busy = 1'b0;
      chk("busy_back_in_difs", int'(state), 1);
      chk("busy_rem_frozen", int'(remaining), 2);
      k = 2;
      while (k < 60 && !grant) begin k++; step(); end
      chk("busy_grant_delay", k, 10);
      done = 1'b1; step(); done = 1'b0;

      // Asynchronous reset in the middle of BACKOFF
      start = 1'b1; slots = W'(3);
      step();
      start = 1'b0;
      k = 0;
      while (k < 50 && state != 2'd2) begin k++; step(); end
      #2 rst = 1'b0;
      #1;
      chk("async_rst_state", int'(state), 0);
      chk("async_rst_grant", int'(grant), 0);
      chk("async_rst_remaining", int'(remaining), 0);
      step();
      rst = 1'b1;
      repeat (6) step();
      chk("post_rst_idle", int'(state), 0);

      // Randomized traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         tick  = ($urandom_range(0, 3) != 0);
         busy  = ($urandom_range(0, 7) == 0);
         start = ($urandom_range(0, 3) == 0);
         slots = W'($urandom_range(0, 5));
         done  = ($urandom_range(0, 2) == 0);
         rst   = ($urandom_range(0, 399) != 0);
         step();
      end
      rst = 1'b1; start = 1'b0; done = 1'b0; busy = 1'b0; tick = 1'b0;
      step();
      run_cmp = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
